// File: rtl/gpio_event_queue.sv
// gpio_event_queue
// Turns per-pin interrupt levels into an ordered stream of pin-ID events.
// Rising edges latch pending bits. A round-robin arbiter moves them into a
// registered show-ahead FIFO, which is drained over a valid/ready handshake.
// Optional build macro: GPIO_EVQ_TIMESTAMP_EN adds a 16-bit free-running
// cycle counter. Its value at the grant edge travels with each ID and is
// presented on event_ts_o.
module gpio_event_queue #(
    parameter int  N_GPIO     = 32,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(N_GPIO),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [N_GPIO-1:0] interrupt_i,
    output logic              event_valid_o,
    output logic [ID_W-1:0]   event_id_o,
`ifdef GPIO_EVQ_TIMESTAMP_EN
    output logic [15:0]       event_ts_o,
`endif
    input  logic              event_ready_i,
    output logic [N_GPIO-1:0] pending_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ID_W + 1;
`ifdef GPIO_EVQ_TIMESTAMP_EN
    localparam int TS_W  = 16;
    localparam int ENT_W = ID_W + TS_W;
`else
    localparam int ENT_W = ID_W;
`endif

    localparam logic [N_GPIO-1:0] ONE_HOT0 = {{(N_GPIO-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_GPIO - 1);
    localparam logic [ID_W-1:0]   ID_ONE   = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0]  SUM_N    = SUM_W'(N_GPIO);
    localparam logic [LVL_W-1:0]  LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    // Edge detect, pending, overflow and arbiter state
    logic [N_GPIO-1:0] int_q_r;
    logic [N_GPIO-1:0] pending_r;
    logic [N_GPIO-1:0] pending_next_s;
    logic [N_GPIO-1:0] rise_s;
    logic [N_GPIO-1:0] grant_vec_s;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   ptr_next_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              grant_found_s;
    logic              grant_s;
    logic              overflow_r;
    logic              overflow_set_s;

    // FIFO state
    logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [LVL_W-1:0]  count_r;
    logic [LVL_W-1:0]  count_next_s;
    logic [ENT_W-1:0]  push_data_s;
    logic [ENT_W-1:0]  head_r;
    logic [ENT_W-1:0]  head_next_s;
    logic              event_valid_r;
    logic              pop_s;
    logic              push_allow_s;
    logic              push_s;

`ifdef GPIO_EVQ_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_cnt_r;
`endif

    // Handshake: pop on accepted head; a pop frees a slot for the same-cycle push
    always_comb begin
        rise_s       = interrupt_i & ~int_q_r;
        pop_s        = event_valid_r & event_ready_i;
        push_allow_s = (count_r < LVL_FULL) | pop_s;
    end

    // Round-robin search: first pending bit at index >= ptr, wrapping modulo N_GPIO
    always_comb begin
        logic [SUM_W-1:0] sum_v;
        logic [ID_W-1:0]  idx_v;
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        for (int k = 0; k < N_GPIO; k++) begin
            sum_v = {1'b0, ptr_r} + SUM_W'(k);
            if (sum_v >= SUM_N) begin
                sum_v = sum_v - SUM_N;
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[ID_W-1:0];
            if (!grant_found_s && pending_r[idx_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = idx_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant resolution, next pending vector, overflow detection and pointer advance
    always_comb begin
        grant_s = grant_found_s & push_allow_s;
        push_s  = grant_s;
        if (grant_s) begin
            grant_vec_s = ONE_HOT0 << grant_idx_s;
            if (grant_idx_s == LAST_ID) begin
                ptr_next_s = {ID_W{1'b0}};
            end else begin
                ptr_next_s = grant_idx_s + ID_ONE;
            end
        end else begin
            grant_vec_s = {N_GPIO{1'b0}};
            ptr_next_s  = ptr_r;
        end
        // A new edge on a bit being granted this cycle is a separate event and re-arms it
        pending_next_s = (pending_r & ~grant_vec_s) | rise_s;
        overflow_set_s = |(rise_s & pending_r & ~grant_vec_s);
    end

    // Entry written into the FIFO on a grant
    always_comb begin
`ifdef GPIO_EVQ_TIMESTAMP_EN
        push_data_s = {ts_cnt_r, grant_idx_s};
`else
        push_data_s = grant_idx_s;
`endif
    end

    // Occupancy update from push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + LVL_ONE;
            2'b01:   count_next_s = count_r - LVL_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Next head entry: the pushed word bypasses storage when it lands at the read slot
    always_comb begin
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Edge history, pending bits, sticky overflow and arbiter pointer
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            int_q_r    <= {N_GPIO{1'b0}};
            pending_r  <= {N_GPIO{1'b0}};
            ptr_r      <= {ID_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            int_q_r   <= interrupt_i;
            pending_r <= pending_next_s;
            ptr_r     <= ptr_next_s;
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // FIFO storage, pointers, occupancy and registered head
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {LVL_W{1'b0}};
            head_r        <= {ENT_W{1'b0}};
            event_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r      <= rd_ptr_next_s;
            count_r       <= count_next_s;
            head_r        <= head_next_s;
            event_valid_r <= (count_next_s != {LVL_W{1'b0}});
        end
    end

`ifdef GPIO_EVQ_TIMESTAMP_EN
    // Free-running cycle counter sampled into each pushed entry
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ts_cnt_r <= {TS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + 16'd1;
        end
    end

    assign event_ts_o = head_r[ENT_W-1:ID_W];
`endif

    assign event_valid_o = event_valid_r;
    assign event_id_o    = head_r[ID_W-1:0];
    assign pending_o     = pending_r;
    assign fifo_level_o  = count_r;
    assign overflow_o    = overflow_r;

endmodule
